// File: rtl/fxp_pkg.sv
// Shared fixed-point formats and the result-buffer entry for the shared multiplier arbiter.
package fxp_pkg;

    localparam int FXP_A_W     = 17;
    localparam int FXP_B_W     = 17;
    localparam int FXP_P_W     = 34;
    localparam int FXP_MUL_LAT = 2;
    // Wide enough for up to 8 requesters; narrower configurations truncate on the way out.
    localparam int RSP_ID_W    = 3;

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic [FXP_P_W-1:0]  product;
        logic                overflow;
        logic                underflow;
    } rsp_entry_t;

endpackage

// File: rtl/fxp_mul_arbiter_if.sv
// Requester and response-consumer signals of the shared multiplier arbiter.
interface fxp_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 17,
    parameter int B_W     = 17,
    parameter int P_W     = 34,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [P_W-1:0]         rsp_product;
    logic                   rsp_overflow;
    logic                   rsp_underflow;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_overflow, rsp_underflow
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_overflow, rsp_underflow
    );
endinterface

// File: rtl/fxp_rsp_fifo.sv
// First-word-fall-through result FIFO with occupancy count; head reads as zero when empty.
module fxp_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign valid = !empty;
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fxp_mul_arbiter.sv
// Round-robin, credit-gated sharing of one pipelined multiplier among several requesters,
// with an in-order result buffer tagged by requester id.
module fxp_mul_arbiter
    import fxp_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int A_W        = FXP_A_W,
    parameter int B_W        = FXP_B_W,
    parameter int P_W        = FXP_P_W,
    parameter int MUL_LAT    = FXP_MUL_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    fxp_mul_arbiter_if.slave    bus,
    output logic [A_W-1:0]      mul_a,
    output logic [B_W-1:0]      mul_b,
    input  logic [P_W-1:0]      mul_product,
    input  logic                mul_overflow,
    input  logic                mul_underflow,
    output logic                busy
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
    localparam int STAGES = MUL_LAT + 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credit_used;
    logic               can_issue;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;
    logic [STAGES-1:0]  tag_valid;
    logic [ID_W-1:0]    tag_id [STAGES];
    logic               result_write;
    rsp_entry_t         wr_entry;
    rsp_entry_t         rd_entry;

    // Registered counts only: a result popped this cycle frees its slot next cycle.
    assign credit_used = (CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_count);
    assign can_issue   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

    always_comb begin
        int idx;
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (can_issue && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!grant_valid && bus.req_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_id    = ID_W'(idx);
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Stage 0 of the tag pipe travels with the operand register feeding the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            tag_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[STAGES-2:0], grant_valid};
            tag_id[0] <= grant_id;
            for (int s = 1; s < STAGES; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
            if (grant_valid) begin
                mul_a <= bus.req_a[grant_id*A_W +: A_W];
                mul_b <= bus.req_b[grant_id*B_W +: B_W];
            end
        end
    end

    assign result_write = tag_valid[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({grant_valid, result_write})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_comb begin
        wr_entry           = '0;
        wr_entry.id        = RSP_ID_W'(tag_id[STAGES-1]);
        wr_entry.product   = mul_product;
        wr_entry.overflow  = mul_overflow;
        wr_entry.underflow = mul_underflow;
    end

    fxp_rsp_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (result_write),
        .wdata (wr_entry),
        .pop   (bus.rsp_ready),
        .rdata (rd_entry),
        .valid (bus.rsp_valid),
        .count (fifo_count)
    );

    assign bus.rsp_id        = rd_entry.id[ID_W-1:0];
    assign bus.rsp_product   = rd_entry.product;
    assign bus.rsp_overflow  = rd_entry.overflow;
    assign bus.rsp_underflow = rd_entry.underflow;

    assign busy = (|tag_valid) | (fifo_count != '0);

endmodule
